riscv_fetch_queue: RTL and testbench

Parametrised successor to the single-entry fetch stage. It keeps up to MAX_OUTSTANDING icache reads in flight and buffers returned instructions in a DEPTH-entry in-order queue feeding decode. It handles branch redirects by flushing the queue and discarding stale responses, and performs FENCE.I-style invalidate-and-refetch. It sits between the icache and the decode stage.

---
 rtl/riscv_fetch_queue_if.sv | 50 +++++
 rtl/riscv_fetch_queue.sv | 171 +++++++++++++++++
 tb/tb_riscv_fetch_queue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_queue_if
//  Purpose  : Decode, icache and redirect signals of the fetch queue.
//  Revision : 1.0
// ============================================================================
interface riscv_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                       fetch_valid_o;
    logic                       fetch_accept_i;
    logic [31:0]                fetch_instr_o;
    logic [31:0]                fetch_pc_o;
    logic                       fetch_fault_fetch_o;
    logic                       fetch_fault_page_o;
    logic                       icache_rd_o;
    logic                       icache_accept_i;
    logic [31:0]                icache_pc_o;
    logic [1:0]                 icache_priv_o;
    logic                       icache_valid_i;
    logic [31:0]                icache_inst_i;
    logic                       icache_error_i;
    logic                       icache_page_fault_i;
    logic                       icache_invalidate_o;
    logic                       fetch_invalidate_i;
    logic                       branch_request_i;
    logic [31:0]                branch_pc_i;
    logic [1:0]                 branch_priv_i;
    logic                       squash_decode_o;
    logic [$clog2(DEPTH+1)-1:0] occupancy_o;

    modport master (
        output fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_fetch_o,
               fetch_fault_page_o, icache_rd_o, icache_pc_o, icache_priv_o,
               icache_invalidate_o, squash_decode_o, occupancy_o,
        input  fetch_accept_i, icache_accept_i, icache_valid_i, icache_inst_i,
               icache_error_i, icache_page_fault_i, fetch_invalidate_i,
               branch_request_i, branch_pc_i, branch_priv_i
    );

    modport slave (
        input  fetch_valid_o, fetch_instr_o, fetch_pc_o, fetch_fault_fetch_o,
               fetch_fault_page_o, icache_rd_o, icache_pc_o, icache_priv_o,
               icache_invalidate_o, squash_decode_o, occupancy_o,
        output fetch_accept_i, icache_accept_i, icache_valid_i, icache_inst_i,
               icache_error_i, icache_page_fault_i, fetch_invalidate_i,
               branch_request_i, branch_pc_i, branch_priv_i
    );
endinterface
`default_nettype wire

// File: rtl/riscv_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_queue
//  Purpose  : Multi-outstanding icache fetcher with in-order instruction queue.
//  Revision : 1.0
// ============================================================================
module riscv_fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] BOOT_VECTOR     = 32'h0000_0000
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    riscv_fetch_queue_if.master    bus
);
    localparam int c_QPW = $clog2(DEPTH);
    localparam int c_CW  = $clog2(DEPTH + 1);
    localparam int c_OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t            r_state, w_state_next;
    logic [31:0]       r_pc_q, r_deliver_pc;
    logic [1:0]        r_priv_q;
    logic [c_QPW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [c_OW-1:0]   r_outstanding, r_discard, w_out_next;
    logic [c_OPW-1:0]  r_pcf_wr, r_pcf_rd;
    logic              r_squash, r_inval;

    logic [31:0]       r_q_pc    [DEPTH];
    logic [31:0]       r_q_instr [DEPTH];
    logic              r_q_err   [DEPTH];
    logic              r_q_pf    [DEPTH];
    logic [31:0]       r_pcf     [MAX_OUTSTANDING];

    logic w_rd, w_hs, w_rsp, w_flush, w_push, w_pop;
    logic [31:0] w_branch_pc;
    logic w_unused_bits;

    assign w_branch_pc   = {bus.branch_pc_i[31:2], 2'b00};
    assign w_unused_bits = &{1'b0, bus.branch_pc_i[1:0]};

    assign w_rd    = (r_state == ST_RUN)
                   && ((int'(r_count) + int'(r_outstanding)) < DEPTH)
                   && (int'(r_outstanding) < MAX_OUTSTANDING);
    assign w_hs    = w_rd & bus.icache_accept_i;
    // A response with nothing in flight belongs to a request dropped by reset.
    assign w_rsp   = bus.icache_valid_i & (r_outstanding != '0);
    assign w_flush = bus.branch_request_i | bus.fetch_invalidate_i;
    assign w_push  = w_rsp & (r_discard == '0) & ~w_flush;
    assign w_pop   = (r_count != '0) & bus.fetch_accept_i & ~w_flush;

    always_comb begin
        w_out_next = r_outstanding;
        if (w_hs && !w_rsp) begin
            w_out_next = r_outstanding + c_OW'(1);
        end else if (!w_hs && w_rsp) begin
            w_out_next = r_outstanding - c_OW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_flush) begin
            w_state_next = ST_RUN;
        end else if (w_push && (bus.icache_error_i || bus.icache_page_fault_i)) begin
            w_state_next = ST_HALT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc_q        <= BOOT_VECTOR;
            r_priv_q      <= 2'b11;
            r_deliver_pc  <= BOOT_VECTOR;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_pcf_wr      <= '0;
            r_pcf_rd      <= '0;
            r_squash      <= 1'b0;
            r_inval       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
                r_q_err[i]   <= 1'b0;
                r_q_pf[i]    <= 1'b0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_pcf[i] <= '0;
            end
        end else begin
            r_outstanding <= w_out_next;
            r_squash      <= w_flush;
            r_inval       <= bus.fetch_invalidate_i;

            // The request-PC FIFO tracks every in-flight read, stale or not.
            if (w_hs) begin
                r_pcf[r_pcf_wr] <= r_pc_q;
                r_pcf_wr <= (r_pcf_wr == c_OPW'(MAX_OUTSTANDING - 1)) ? '0 : r_pcf_wr + c_OPW'(1);
            end
            if (w_rsp) begin
                r_pcf_rd <= (r_pcf_rd == c_OPW'(MAX_OUTSTANDING - 1)) ? '0 : r_pcf_rd + c_OPW'(1);
            end

            if (w_flush) begin
                // Discard is a subset of outstanding: every read still in
                // flight after this cycle is stale.
                r_discard <= w_out_next;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                if (bus.branch_request_i) begin
                    r_pc_q       <= w_branch_pc;
                    r_priv_q     <= bus.branch_priv_i;
                    r_deliver_pc <= w_branch_pc;
                end else begin
                    r_pc_q <= r_deliver_pc;
                end
            end else begin
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - c_OW'(1);
                end
                if (w_hs) begin
                    r_pc_q <= r_pc_q + 32'd4;
                end
                if (w_push) begin
                    r_q_pc[r_wr_ptr]    <= r_pcf[r_pcf_rd];
                    r_q_instr[r_wr_ptr] <= bus.icache_inst_i;
                    r_q_err[r_wr_ptr]   <= bus.icache_error_i;
                    r_q_pf[r_wr_ptr]    <= bus.icache_page_fault_i;
                    r_wr_ptr            <= r_wr_ptr + c_QPW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr     <= r_rd_ptr + c_QPW'(1);
                    r_deliver_pc <= r_q_pc[r_rd_ptr] + 32'd4;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CW'(1);
                end
            end
        end
    end

    assign bus.fetch_valid_o       = (r_count != '0);
    assign bus.fetch_instr_o       = r_q_instr[r_rd_ptr];
    assign bus.fetch_pc_o          = r_q_pc[r_rd_ptr];
    assign bus.fetch_fault_fetch_o = r_q_err[r_rd_ptr];
    assign bus.fetch_fault_page_o  = r_q_pf[r_rd_ptr];
    assign bus.icache_rd_o         = w_rd;
    assign bus.icache_pc_o         = r_pc_q;
    assign bus.icache_priv_o       = r_priv_q;
    assign bus.icache_invalidate_o = r_inval;
    assign bus.squash_decode_o     = r_squash;
    assign bus.occupancy_o         = r_count;
endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_fetch_queue
//  Purpose  : Directed self-checking bench for riscv_fetch_queue.
//  Revision : 1.0
// ============================================================================
module tb_riscv_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    riscv_fetch_queue_if #(.DEPTH(4)) bus ();

    riscv_fetch_queue #(
        .DEPTH(4),
        .MAX_OUTSTANDING(2),
        .BOOT_VECTOR(32'h0000_0000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ic(input logic acc, input logic vld, input logic [31:0] inst,
                      input logic err, input logic pf);
        bus.icache_accept_i     = acc;
        bus.icache_valid_i      = vld;
        bus.icache_inst_i       = inst;
        bus.icache_error_i      = err;
        bus.icache_page_fault_i = pf;
    endtask

    task automatic branch(input logic [31:0] pc, input logic [1:0] priv);
        bus.branch_request_i = 1'b1;
        bus.branch_pc_i      = pc;
        bus.branch_priv_i    = priv;
        tick();
        bus.branch_request_i = 1'b0;
    endtask

    initial begin
        bus.fetch_accept_i     = 1'b0;
        bus.fetch_invalidate_i = 1'b0;
        bus.branch_request_i   = 1'b0;
        bus.branch_pc_i        = '0;
        bus.branch_priv_i      = '0;
        ic(0, 0, 32'h0, 0, 0);
        tick();
        tick();
        chk("rst_valid", bus.fetch_valid_o, 0);
        chk("rst_occ", bus.occupancy_o, 0);
        chk("rst_pc", bus.icache_pc_o, 32'h0);
        chk("rst_priv", bus.icache_priv_o, 2'b11);
        chk("rst_squash", bus.squash_decode_o, 0);
        chk("rst_inval", bus.icache_invalidate_o, 0);
        rst = 1'b0;
        chk("boot_rd", bus.icache_rd_o, 1);

        // Streaming: accept every cycle, respond one cycle later.
        ic(1, 0, 32'h0, 0, 0);
        tick();
        chk("s1_pc", bus.icache_pc_o, 32'h4);
        chk("s1_rd", bus.icache_rd_o, 1);
        ic(1, 1, 32'h0000_0013, 0, 0);
        tick();
        chk("s2_valid", bus.fetch_valid_o, 1);
        chk("s2_head_pc", bus.fetch_pc_o, 32'h0);
        chk("s2_instr", bus.fetch_instr_o, 32'h0000_0013);
        chk("s2_occ", bus.occupancy_o, 1);
        tick();
        chk("s3_occ", bus.occupancy_o, 2);
        tick();
        chk("s4_occ", bus.occupancy_o, 3);
        chk("s4_rd_drop", bus.icache_rd_o, 0);
        tick();
        chk("s5_occ", bus.occupancy_o, 4);
        chk("s5_rd", bus.icache_rd_o, 0);
        ic(0, 0, 32'h0, 0, 0);
        tick();
        chk("s6_occ_sat", bus.occupancy_o, 4);
        bus.fetch_accept_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("order_pc", bus.fetch_pc_o, 32'(i * 4));
            tick();
        end
        bus.fetch_accept_i = 1'b0;
        chk("drained", bus.fetch_valid_o, 0);
        chk("next_pc", bus.icache_pc_o, 32'h10);

        // Branch with two reads in flight.
        ic(1, 0, 32'h0, 0, 0);
        tick();
        tick();
        chk("b_rd_cap", bus.icache_rd_o, 0);
        ic(0, 0, 32'h0, 0, 0);
        branch(32'h0000_1003, 2'b11);
        chk("b_pc", bus.icache_pc_o, 32'h1000);
        chk("b_squash", bus.squash_decode_o, 1);
        ic(0, 1, 32'hDEAD_BEEF, 0, 0);
        tick();
        chk("b_squash_end", bus.squash_decode_o, 0);
        chk("b_drop1", bus.occupancy_o, 0);
        tick();
        chk("b_drop2", bus.occupancy_o, 0);
        ic(1, 0, 32'h0, 0, 0);
        tick();
        ic(0, 1, 32'h0010_0093, 0, 0);
        tick();
        ic(0, 0, 32'h0, 0, 0);
        chk("b_valid", bus.fetch_valid_o, 1);
        chk("b_head_pc", bus.fetch_pc_o, 32'h1000);
        chk("b_instr", bus.fetch_instr_o, 32'h0010_0093);
        bus.fetch_accept_i = 1'b1;
        tick();
        bus.fetch_accept_i = 1'b0;

        // Page fault halts fetch until redirected.
        branch(32'h0000_2000, 2'b11);
        ic(1, 0, 32'h0, 0, 0);
        tick();
        ic(0, 1, 32'h0, 0, 1);
        tick();
        ic(0, 0, 32'h0, 0, 0);
        chk("pf_valid", bus.fetch_valid_o, 1);
        chk("pf_pc", bus.fetch_pc_o, 32'h2000);
        chk("pf_flag", bus.fetch_fault_page_o, 1);
        chk("pf_busflag", bus.fetch_fault_fetch_o, 0);
        chk("pf_halt_rd", bus.icache_rd_o, 0);
        tick();
        chk("pf_halt_rd2", bus.icache_rd_o, 0);
        branch(32'h0000_3000, 2'b01);
        chk("pf_resume_rd", bus.icache_rd_o, 1);
        chk("pf_resume_pc", bus.icache_pc_o, 32'h3000);
        chk("pf_resume_priv", bus.icache_priv_o, 2'b01);
        chk("pf_flushed", bus.fetch_valid_o, 0);

        // Deliver 0x0 and 0x4, then invalidate with 0x8 queued.
        branch(32'h0000_0000, 2'b11);
        ic(1, 0, 32'h0, 0, 0);
        tick();
        ic(1, 1, 32'h0000_0013, 0, 0);
        tick();
        tick();
        ic(0, 1, 32'h0000_0013, 0, 0);
        tick();
        ic(0, 0, 32'h0, 0, 0);
        chk("i_occ", bus.occupancy_o, 3);
        bus.fetch_accept_i = 1'b1;
        chk("i_head0", bus.fetch_pc_o, 32'h0);
        tick();
        chk("i_head4", bus.fetch_pc_o, 32'h4);
        tick();
        bus.fetch_accept_i = 1'b0;
        chk("i_head8", bus.fetch_pc_o, 32'h8);
        bus.fetch_invalidate_i = 1'b1;
        tick();
        bus.fetch_invalidate_i = 1'b0;
        chk("i_pc", bus.icache_pc_o, 32'h8);
        chk("i_pulse", bus.icache_invalidate_o, 1);
        chk("i_squash", bus.squash_decode_o, 1);
        chk("i_flushed", bus.occupancy_o, 0);
        tick();
        chk("i_pulse_end", bus.icache_invalidate_o, 0);
        ic(1, 0, 32'h0, 0, 0);
        tick();
        chk("i_next_pc", bus.icache_pc_o, 32'hC);
        ic(0, 1, 32'h0000_0013, 0, 0);
        tick();
        ic(0, 0, 32'h0, 0, 0);
        chk("i_refetch", bus.fetch_pc_o, 32'h8);
        bus.fetch_accept_i = 1'b1;
        tick();
        bus.fetch_accept_i = 1'b0;

        // Branch and invalidate together.
        bus.fetch_invalidate_i = 1'b1;
        branch(32'h0000_4000, 2'b11);
        bus.fetch_invalidate_i = 1'b0;
        chk("bi_pc", bus.icache_pc_o, 32'h4000);
        chk("bi_pulse", bus.icache_invalidate_o, 1);
        chk("bi_squash", bus.squash_decode_o, 1);
        ic(1, 0, 32'h0, 0, 0);
        tick();
        ic(0, 1, 32'h0000_0013, 0, 0);
        tick();
        ic(0, 0, 32'h0, 0, 0);
        chk("bi_head", bus.fetch_pc_o, 32'h4000);
        bus.fetch_accept_i = 1'b1;
        tick();
        bus.fetch_accept_i = 1'b0;

        // PC wraps past the top of the address space.
        branch(32'hFFFF_FFFC, 2'b11);
        ic(1, 0, 32'h0, 0, 0);
        tick();
        chk("wrap_pc", bus.icache_pc_o, 32'h0);
        ic(0, 1, 32'h0000_0013, 0, 0);
        tick();
        chk("wrap_head", bus.fetch_pc_o, 32'hFFFF_FFFC);
        tick();
        ic(0, 0, 32'h0, 0, 0);
        chk("stray_rsp", bus.occupancy_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
